slave_port_arbiter: RTL

Arbitrates one AXI slave's single SRAM port between its read engine and its write engine. Drives the two-bit `select` that gates both engines and multiplexes their SRAM address, data and control onto the macro. Sits inside each SRAM-backed slave wrapper, between the AXI slave engines and the SRAM instance. Grants one full burst at a time and uses round-robin on simultaneous requests.

---
 rtl/slave_arb_pkg.sv | 21 ++
 rtl/slave_port_arbiter.sv | 109 ++++++++++
 2 files changed

// File: rtl/slave_arb_pkg.sv
// Shared definitions for the SRAM port arbiter and the AXI slave engines.
//   SEL_*        : two-bit engine grant encodings driven on `select`
//   arb_state_e  : arbiter FSM states, encoded to match the SEL_* values
//   LAST_*       : round-robin history values for the last granted engine
package slave_arb_pkg;

  localparam logic [1:0] SEL_IDLE  = 2'b00;
  localparam logic [1:0] SEL_READ  = 2'b01;
  localparam logic [1:0] SEL_WRITE = 2'b10;

  // State encodings equal the select encodings so `select` is the state register itself.
  typedef enum logic [1:0] {
    StIdle  = SEL_IDLE,
    StRead  = SEL_READ,
    StWrite = SEL_WRITE
  } arb_state_e;

  localparam logic LAST_READ  = 1'b0;
  localparam logic LAST_WRITE = 1'b1;

endpackage

// File: rtl/slave_port_arbiter.sv
// Arbitrates a single SRAM port between an AXI slave's read and write engines.
// One whole burst is granted at a time; simultaneous requests alternate round-robin.
//
// Ports:
//   clock, reset           : clock and asynchronous active-low reset
//   ARVALID, AWVALID       : level-sensitive read / write requests
//   read_finish            : read burst complete (honoured only while reading)
//   write_finish           : write burst complete (honoured only while writing)
//   read_addr              : read engine SRAM address
//   write_addr/web/data    : write engine SRAM address, byte enables (active-low), data
//   select                 : engine grant (SEL_IDLE / SEL_READ / SEL_WRITE)
//   sram_CS/OE/WEB/A/DI    : multiplexed SRAM macro controls
module slave_port_arbiter
  import slave_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ARVALID,
  input  logic              AWVALID,
  input  logic              read_finish,
  input  logic              write_finish,
  input  logic [ADDR_W-1:0] read_addr,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [3:0]        write_web,
  input  logic [DATA_W-1:0] write_data,
  output logic [1:0]        select,
  output logic              sram_CS,
  output logic              sram_OE,
  output logic [3:0]        sram_WEB,
  output logic [ADDR_W-1:0] sram_A,
  output logic [DATA_W-1:0] sram_DI
);

  arb_state_e r_state;
  arb_state_e w_state_d;
  logic       r_last_grant;
  logic       w_last_grant_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= StIdle;
      // Start as if WRITE was last served so the first tie goes to READ.
      r_last_grant <= LAST_WRITE;
    end else begin
      r_state      <= w_state_d;
      r_last_grant <= w_last_grant_d;
    end
  end

  always_comb begin
    w_state_d      = r_state;
    w_last_grant_d = r_last_grant;
    case (r_state)
      StIdle: begin
        if (ARVALID && AWVALID) begin
          if (r_last_grant == LAST_WRITE) begin
            w_state_d      = StRead;
            w_last_grant_d = LAST_READ;
          end else begin
            w_state_d      = StWrite;
            w_last_grant_d = LAST_WRITE;
          end
        end else if (ARVALID) begin
          w_state_d      = StRead;
          w_last_grant_d = LAST_READ;
        end else if (AWVALID) begin
          w_state_d      = StWrite;
          w_last_grant_d = LAST_WRITE;
        end
      end
      StRead: begin
        if (read_finish) w_state_d = StIdle;
      end
      StWrite: begin
        if (write_finish) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign select = r_state;

  // Purely combinational from state so an async reset parks the macro immediately.
  always_comb begin
    sram_CS  = 1'b0;
    sram_OE  = 1'b0;
    sram_WEB = 4'hF;
    sram_A   = '0;
    sram_DI  = '0;
    case (r_state)
      StRead: begin
        sram_CS = 1'b1;
        sram_OE = 1'b1;
        sram_A  = read_addr;
      end
      StWrite: begin
        sram_CS  = 1'b1;
        sram_WEB = write_web;
        sram_A   = write_addr;
        sram_DI  = write_data;
      end
      default: ;
    endcase
  end

endmodule
